mode_counter: RTL and testbench

//   Parametrised up/down counter; successor to the fixed 8-bit enable/pause Counter.

---
 rtl/counter_pkg.sv | 10 +
 rtl/counter_prescaler.sv | 31 +++
 rtl/mode_counter.sv | 86 ++++++++
 tb/tb_mode_counter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the mode_counter family: direction and limit-behaviour codes.
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// Step qualifier for mode_counter: tick is high while the phase counter sits at PRESCALE-1.
// Built only when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int              PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = (phase == LAST);

    // clr covers load and !enable; hold keeps the phase across a pause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (!hold) begin
            phase <= tick ? '0 : phase + PW'(1);
        end
    end

endmodule : counter_prescaler

// File: rtl/mode_counter.sv
// Parametrised up/down wrap/saturate counter with synchronous load and terminal-count pulse.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module mode_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pause,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    if (MAX_VAL == '0) begin : g_bad_max_val
        $error("mode_counter: MAX_VAL must be non-zero");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mode_counter: PRESCALE must be >= 1");
    end

    logic             step_ok;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load | ~enable),
        .hold (pause),
        .tick (step_ok)
    );
`else
    assign step_ok = 1'b1;
`endif

    // Priority: load > !enable > pause > step. tc is only raised by a boundary step.
    always_comb begin
        count_d = count;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (!enable) begin
            count_d = '0;
        end else if (pause) begin
            count_d = count;
        end else if (step_ok) begin
            if (dir == DIR_UP) begin
                if (count == MAX_VAL) begin
                    count_d = (mode == MODE_SAT) ? MAX_VAL : '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    count_d = (mode == MODE_SAT) ? '0 : MAX_VAL;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_d;
            tc    <= tc_d;
        end
    end

endmodule : mode_counter

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter (WIDTH=8, MAX_VAL=9); prescaler scenario runs when
// COUNTER_PRESCALE_EN is defined.
module tb_mode_counter;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         enable   = 1'b0;
    logic         pause    = 1'b0;
    logic         dir      = 1'b1;
    logic         mode     = 1'b0;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         tc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    mode_counter #(
        .WIDTH    (W),
        .MAX_VAL  (8'd9),
        .PRESCALE (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .pause    (pause),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc)
    );

`ifdef COUNTER_PRESCALE_EN
    logic [W-1:0] count_ps;
    logic         tc_ps;

    mode_counter #(
        .WIDTH    (W),
        .MAX_VAL  (8'd9),
        .PRESCALE (3)
    ) dut_ps (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .pause    (pause),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .count    (count_ps),
        .tc       (tc_ps)
    );
`endif

    // driver tasks
    task automatic drive(input logic en, input logic pa, input logic di, input logic mo,
                         input logic ld, input logic [W-1:0] lv);
        @(negedge clk);
        enable   = en;
        pause    = pa;
        dir      = di;
        mode     = mo;
        load     = ld;
        load_val = lv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (count !== 8'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", count);
        end
        n_checks++;
        if (tc !== 1'b0) begin
            n_fail++; $display("FAIL reset_tc: got %0b want 0", tc);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        n_checks++;
        if (count !== 8'd0) begin
            n_fail++; $display("FAIL reset_held: got %0d want 0", count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [W-1:0] seq[12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6,
                                  8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd2};
        logic [W-1:0] want;
        for (int i = 0; i < 12; i++) exp_q.push_back(seq[i]);
        for (int i = 0; i < 12; i++) begin
            tick();
            want = exp_q.pop_front();
            n_checks++;
            if (count !== want) begin
                n_fail++; $display("FAIL wrap_up_count[%0d]: got %0d want %0d", i, count, want);
            end
            n_checks++;
            if (tc !== (i == 9)) begin
                n_fail++; $display("FAIL wrap_up_tc[%0d]: got %0b want %0b", i, tc, (i == 9));
            end
        end
    endtask

    task automatic test_sat_down();
        logic [W-1:0] c_seq[4]  = '{8'd1, 8'd0, 8'd0, 8'd0};
        logic         tc_seq[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
        tick();
        n_checks++;
        if (count !== 8'd2 || tc !== 1'b0) begin
            n_fail++; $display("FAIL sat_down_load: got %0d/%0b want 2/0", count, tc);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (count !== c_seq[i] || tc !== tc_seq[i]) begin
                n_fail++;
                $display("FAIL sat_down[%0d]: got %0d/%0b want %0d/%0b", i, count, tc, c_seq[i], tc_seq[i]);
            end
        end
    endtask

    task automatic test_load_clamp();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd200);
        tick();
        n_checks++;
        if (count !== 8'd9 || tc !== 1'b0) begin
            n_fail++; $display("FAIL load_clamp: got %0d/%0b want 9/0", count, tc);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4);
        tick();
        n_checks++;
        if (count !== 8'd4) begin
            n_fail++; $display("FAIL load_over_disable: got %0d want 4", count);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        tick();
        n_checks++;
        if (count !== 8'd0 || tc !== 1'b0) begin
            n_fail++; $display("FAIL disable_clear: got %0d/%0b want 0/0", count, tc);
        end
    endtask

    task automatic test_wrap_down();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        n_checks++;
        if (count !== 8'd9 || tc !== 1'b1) begin
            n_fail++; $display("FAIL wrap_down_edge: got %0d/%0b want 9/1", count, tc);
        end
        tick();
        n_checks++;
        if (count !== 8'd8 || tc !== 1'b0) begin
            n_fail++; $display("FAIL wrap_down_next: got %0d/%0b want 8/0", count, tc);
        end
    endtask

    task automatic test_sat_up();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd9);
        tick();
        n_checks++;
        if (count !== 8'd9 || tc !== 1'b0) begin
            n_fail++; $display("FAIL sat_up_load: got %0d/%0b want 9/0", count, tc);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (count !== 8'd9 || tc !== 1'b1) begin
                n_fail++; $display("FAIL sat_up_hold[%0d]: got %0d/%0b want 9/1", i, count, tc);
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        n_checks++;
        if (count !== 8'd9 || tc !== 1'b0) begin
            n_fail++; $display("FAIL sat_up_pause: got %0d/%0b want 9/0", count, tc);
        end
    endtask

    task automatic test_pause();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (count !== 8'd5 || tc !== 1'b0) begin
                n_fail++; $display("FAIL pause_hold[%0d]: got %0d/%0b want 5/0", i, count, tc);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        n_checks++;
        if (count !== 8'd0 || tc !== 1'b0) begin
            n_fail++; $display("FAIL disable_over_pause: got %0d/%0b want 0/0", count, tc);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd6);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        n_checks++;
        if (count !== 8'd7) begin
            n_fail++; $display("FAIL async_pre: got %0d want 7", count);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 8'd0 || tc !== 1'b0) begin
            n_fail++; $display("FAIL async_clear: got %0d/%0b want 0/0", count, tc);
        end
        #1 rst = 1'b0;
        tick();
        n_checks++;
        if (count !== 8'd1) begin
            n_fail++; $display("FAIL async_resume: got %0d want 1", count);
        end
        // reset landing while tc is high must drop it too
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd9);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        n_checks++;
        if (count !== 8'd0 || tc !== 1'b1) begin
            n_fail++; $display("FAIL async_tc_pre: got %0d/%0b want 0/1", count, tc);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (tc !== 1'b0) begin
            n_fail++; $display("FAIL async_tc_clear: got %0b want 0", tc);
        end
        #1 rst = 1'b0;
    endtask

`ifdef COUNTER_PRESCALE_EN
    task automatic test_prescale();
        logic [W-1:0] seq[9] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3};
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if (count_ps !== seq[i]) begin
                n_fail++; $display("FAIL prescale[%0d]: got %0d want %0d", i, count_ps, seq[i]);
            end
        end
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        n_checks++;
        if (count_ps !== 8'd3) begin
            n_fail++; $display("FAIL prescale_phase_hold: got %0d want 3", count_ps);
        end
        tick();
        n_checks++;
        if (count_ps !== 8'd4) begin
            n_fail++; $display("FAIL prescale_phase_step: got %0d want 4", count_ps);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_wrap_down();
        test_sat_up();
        test_pause();
        test_async_reset();
`ifdef COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mode_counter
